// File: rtl/fft_pair_ram_if.sv
// Handshake and data bundle between the FFT operand/result memory and its
// neighbours: sample front end (load), butterfly engine (pair read/write)
// and the spectrum consumer (unload). The memory uses the slave view.
interface fft_pair_ram_if #(
  parameter int BIT_WIDTH = 29,
  parameter int SIZE      = 4
);
  // Frame control
  logic                        start;
  logic                        busy;
  // Sample load
  logic                        load_valid;
  logic signed [BIT_WIDTH-1:0] load_re;
  logic signed [BIT_WIDTH-1:0] load_im;
  logic                        load_done;
  // Butterfly operand read
  logic                        rd_en;
  logic        [SIZE-1:0]      rd_adr_a;
  logic        [SIZE-1:0]      rd_adr_b;
  logic signed [BIT_WIDTH-1:0] re_a;
  logic signed [BIT_WIDTH-1:0] im_a;
  logic signed [BIT_WIDTH-1:0] re_b;
  logic signed [BIT_WIDTH-1:0] im_b;
  logic                        pair_valid;
  // Butterfly result write
  logic                        wr_en;
  logic        [SIZE-1:0]      wr_adr_a;
  logic        [SIZE-1:0]      wr_adr_b;
  logic signed [BIT_WIDTH-1:0] wr_re_a;
  logic signed [BIT_WIDTH-1:0] wr_im_a;
  logic signed [BIT_WIDTH-1:0] wr_re_b;
  logic signed [BIT_WIDTH-1:0] wr_im_b;
  // Spectrum unload
  logic                        fft_done;
  logic signed [BIT_WIDTH-1:0] out_re;
  logic signed [BIT_WIDTH-1:0] out_im;
  logic                        out_valid;
  logic                        out_last;

  modport slave (
    input  start, load_valid, load_re, load_im,
    input  rd_en, rd_adr_a, rd_adr_b,
    input  wr_en, wr_adr_a, wr_adr_b, wr_re_a, wr_im_a, wr_re_b, wr_im_b,
    input  fft_done,
    output busy, load_done, re_a, im_a, re_b, im_b, pair_valid,
    output out_re, out_im, out_valid, out_last
  );

  modport master (
    output start, load_valid, load_re, load_im,
    output rd_en, rd_adr_a, rd_adr_b,
    output wr_en, wr_adr_a, wr_adr_b, wr_re_a, wr_im_a, wr_re_b, wr_im_b,
    output fft_done,
    input  busy, load_done, re_a, im_a, re_b, im_b, pair_valid,
    input  out_re, out_im, out_valid, out_last
  );
endinterface

// File: rtl/fft_pair_ram.sv
// Operand/result memory for the sequential FFT. Two mirrored banks give two
// independent read ports; every write lands in both banks. Samples are loaded
// (optionally bit-reversed), served as butterfly pairs, then unloaded in
// natural order.
module fft_pair_ram #(
  parameter int BIT_WIDTH   = 29,
  parameter int SIZE        = 4,
  parameter int N           = 16,
  parameter int BITREV_LOAD = 1
) (
  input  logic          clk,
  input  logic          rst,
  fft_pair_ram_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_COMPUTE = 2'd2,
    S_UNLOAD  = 2'd3
  } state_t;

  localparam logic [SIZE-1:0] LAST_IDX = SIZE'(N - 1);

  // Mirrored banks: bank A feeds read port A and the unload stream, bank B port B.
  logic signed [BIT_WIDTH-1:0] r_bank_a_re [N];
  logic signed [BIT_WIDTH-1:0] r_bank_a_im [N];
  logic signed [BIT_WIDTH-1:0] r_bank_b_re [N];
  logic signed [BIT_WIDTH-1:0] r_bank_b_im [N];

  state_t                      r_state;
  logic        [SIZE-1:0]      r_cnt;
  logic                        r_busy;
  logic                        r_load_done;
  logic                        r_pair_valid;
  logic                        r_out_valid;
  logic                        r_out_last;
  logic signed [BIT_WIDTH-1:0] r_re_a;
  logic signed [BIT_WIDTH-1:0] r_im_a;
  logic signed [BIT_WIDTH-1:0] r_re_b;
  logic signed [BIT_WIDTH-1:0] r_im_b;
  logic signed [BIT_WIDTH-1:0] r_out_re;
  logic signed [BIT_WIDTH-1:0] r_out_im;

  logic                        w_ld_we;
  logic        [SIZE-1:0]      w_ld_adr;
  logic                        w_pair_we;

  function automatic logic [SIZE-1:0] bitrev(input logic [SIZE-1:0] x);
    logic [SIZE-1:0] y;
    y = '0;
    for (int i = 0; i < SIZE; i++) begin
      y[i] = x[SIZE-1-i];
    end
    return y;
  endfunction

  // Decode memory write enables and the load address from the current state.
  always_comb begin
    w_ld_we   = 1'b0;
    w_ld_adr  = r_cnt;
    w_pair_we = 1'b0;
    if ((r_state == S_LOAD) && bus.load_valid) begin
      w_ld_we = 1'b1;
    end else begin
      w_ld_we = 1'b0;
    end
    if (BITREV_LOAD != 0) begin
      w_ld_adr = bitrev(r_cnt);
    end else begin
      w_ld_adr = r_cnt;
    end
    if ((r_state == S_COMPUTE) && bus.wr_en) begin
      w_pair_we = 1'b1;
    end else begin
      w_pair_we = 1'b0;
    end
  end

  // Memory array writes (no reset); port b is written last so it wins on equal addresses.
  always_ff @(posedge clk) begin
    if (w_ld_we) begin
      r_bank_a_re[w_ld_adr] <= bus.load_re;
      r_bank_a_im[w_ld_adr] <= bus.load_im;
      r_bank_b_re[w_ld_adr] <= bus.load_re;
      r_bank_b_im[w_ld_adr] <= bus.load_im;
    end
    if (w_pair_we) begin
      r_bank_a_re[bus.wr_adr_a] <= bus.wr_re_a;
      r_bank_a_im[bus.wr_adr_a] <= bus.wr_im_a;
      r_bank_b_re[bus.wr_adr_a] <= bus.wr_re_a;
      r_bank_b_im[bus.wr_adr_a] <= bus.wr_im_a;
      r_bank_a_re[bus.wr_adr_b] <= bus.wr_re_b;
      r_bank_a_im[bus.wr_adr_b] <= bus.wr_im_b;
      r_bank_b_re[bus.wr_adr_b] <= bus.wr_re_b;
      r_bank_b_im[bus.wr_adr_b] <= bus.wr_im_b;
    end
  end

  // Frame FSM with registered pulses, pair read port and unload stream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_busy       <= 1'b0;
      r_load_done  <= 1'b0;
      r_pair_valid <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_re_a       <= '0;
      r_im_a       <= '0;
      r_re_b       <= '0;
      r_im_b       <= '0;
      r_out_re     <= '0;
      r_out_im     <= '0;
    end else begin
      r_load_done  <= 1'b0;
      r_pair_valid <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state <= S_LOAD;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          if (bus.load_valid) begin
            r_cnt <= r_cnt + SIZE'(1);
            if (r_cnt == LAST_IDX) begin
              r_load_done <= 1'b1;
              r_state     <= S_COMPUTE;
            end
          end
        end
        S_COMPUTE: begin
          // Reads see the pre-edge contents, so a same-cycle write is not visible yet.
          if (bus.rd_en) begin
            r_re_a       <= r_bank_a_re[bus.rd_adr_a];
            r_im_a       <= r_bank_a_im[bus.rd_adr_a];
            r_re_b       <= r_bank_b_re[bus.rd_adr_b];
            r_im_b       <= r_bank_b_im[bus.rd_adr_b];
            r_pair_valid <= 1'b1;
          end
          if (bus.fft_done) begin
            r_state <= S_UNLOAD;
            r_cnt   <= '0;
          end
        end
        S_UNLOAD: begin
          r_out_re    <= r_bank_a_re[r_cnt];
          r_out_im    <= r_bank_a_im[r_cnt];
          r_out_valid <= 1'b1;
          r_cnt       <= r_cnt + SIZE'(1);
          if (r_cnt == LAST_IDX) begin
            r_out_last <= 1'b1;
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_cnt      <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.busy       = r_busy;
  assign bus.load_done  = r_load_done;
  assign bus.pair_valid = r_pair_valid;
  assign bus.re_a       = r_re_a;
  assign bus.im_a       = r_im_a;
  assign bus.re_b       = r_re_b;
  assign bus.im_b       = r_im_b;
  assign bus.out_re     = r_out_re;
  assign bus.out_im     = r_out_im;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_last   = r_out_last;

endmodule

// File: doc/fft_pair_ram.md
# fft_pair_ram

Parametrised operand/result memory for the sequential FFT datapath. It loads N complex input samples into bit-reversed addresses and serves two butterfly operands per cycle. It accepts two butterfly results per cycle and streams the finished spectrum out in natural order. It sits between the sample front end and the butterfly/twiddle engine, replacing the single-port, two-cycle pair-assembly memory.

## Interface
Parameters:
- BIT_WIDTH, 29, width of each real/imag component (signed)
- SIZE, 4, log2 of FFT length; address width
- N, 16, FFT length; must equal 2**SIZE
- BITREV_LOAD, 1, 1 = load into bit-reversed address, 0 = natural order

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset (one clock; reset asynchronous active-high)
- start  in  1  begin a new frame (honoured in IDLE only)
- load_valid  in  1  input sample strobe
- load_re, load_im  in  BIT_WIDTH  input sample
- load_done  out  1  one-cycle pulse, Nth sample written
- rd_en  in  1  butterfly pair read request
- rd_adr_a, rd_adr_b  in  SIZE  operand addresses
- re_a, im_a, re_b, im_b  out  BIT_WIDTH  operand data
- pair_valid  out  1  operand data valid
- wr_en  in  1  butterfly pair write
- wr_adr_a, wr_adr_b  in  SIZE  result addresses
- wr_re_a, wr_im_a, wr_re_b, wr_im_b  in  BIT_WIDTH  result data
- fft_done  in  1  last butterfly written; begin unload
- out_re, out_im  out  BIT_WIDTH  spectrum sample
- out_valid  out  1  spectrum sample valid
- out_last  out  1  with the Nth spectrum sample
- busy  out  1  state != IDLE

## Operation
- Storage: two separate banks, each with N x (re, im) words. A write to address x goes to both banks, giving two independent read ports. Memory contents are not reset.
- FSM states IDLE, LOAD, COMPUTE, UNLOAD; reset state IDLE.
- IDLE: start -> LOAD, load counter cleared. All other control inputs ignored.
- LOAD: each load_valid writes sample k (counter 0..N-1) to bitrev(k) (SIZE-bit reversal) or k when BITREV_LOAD=0. On the Nth write: load_done pulses and the FSM goes to COMPUTE. rd_en, wr_en and fft_done are ignored.
- COMPUTE: rd_en reads both addresses. wr_en writes both results.
  - wr_adr_a == wr_adr_b: the b data wins.
  - Read and write of the same address in the same cycle: the read returns the old contents.
  - fft_done -> UNLOAD, unload counter cleared. A wr_en in that same cycle is still performed. load_valid is ignored.
- UNLOAD: reads address 0..N-1 in natural order, one per cycle, with no stall. After address N-1 is read, the FSM goes to IDLE. All inputs other than rst are ignored.
- rst at any time: FSM to IDLE, counters to 0, all outputs to reset values. An in-flight pair read or unload word is discarded.
- No arithmetic is performed; data passes bit-exact, sign preserved.

## Timing
- Reset values: load_done=0, pair_valid=0, out_valid=0, out_last=0, busy=0, all data outputs 0.
- Load write latency: sample is in memory on the edge where load_valid is sampled. load_done is high the cycle after that edge.
- Pair read latency is 1 cycle: rd_en at edge t gives pair_valid and data during cycle t+1. Back-to-back rd_en gives one pair per cycle. Data outputs hold their value when pair_valid=0.
- Write latency is 0: data written at edge t is readable by an rd_en sampled at edge t+1.
- Unload: first out_valid is 2 cycles after the edge sampling fft_done. Then out_valid stays high for exactly N consecutive cycles. out_last is high on the Nth. busy falls in the same cycle as the last out_valid.
- start can be accepted the cycle after busy falls.

## Test plan
- Bit-reversed load, N=16: load re=k, im=-k for k=0..15, then read pair (8,0) -> re_a=1, im_a=-1, re_b=0, im_b=0, pair_valid one cycle after rd_en. load_done pulses once, after the 16th sample.
- Natural load (BITREV_LOAD=0): the same stimulus, then read pair (3,12) -> re_a=3, re_b=12.
- Read/write collision: in COMPUTE, with mem[5].re=7, issue rd_en at (5,6) and wr_en writing 100 to address 5 in the same cycle -> re_a=7. A read of 5 on the next cycle returns 100.
- Duplicate write address: wr_adr_a=wr_adr_b=2 with wr_re_a=1, wr_re_b=2 -> mem[2].re=2.
- Unload: fft_done after a known memory pattern -> 16 consecutive out_valid cycles with addresses 0..15 in order. out_last is only on the 16th. busy is 0 on the next cycle. Max-negative value -2^28 passes unchanged.
- Mid-operation reset: assert rst during the 8th unload beat -> out_valid, out_last and busy drop to 0 immediately. A subsequent start runs a clean 16-sample load.
